adc_reader: RTL and testbench
=============================

ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in CLK cycles; legal range 2..255.
REQ-002 SHALL have parameter LEAD_BITS, default 4: leading zero bits per ADC frame, discarded.
REQ-003 SHALL have parameter DATA_BITS, default 12: conversion width, MSB first.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 LATCH  input  1  conversion request from the motor driver; rising edge starts a conversion.
REQ-007 ADC_CMP  input  12  unsigned overcurrent threshold.
REQ-008 CLR_OC  input  1  synchronous clear of OVERCURRENT.
REQ-009 SDO  input  1  serial data from the external ADC.
REQ-010 CS_N  output  1  ADC chip select, active low.
REQ-011 SCLK  output  1  ADC serial clock, idles high.
REQ-012 ADC  output  12  last complete conversion, unsigned.
REQ-013 VALID  output  1  one-cycle pulse when ADC updates.
REQ-014 BUSY  output  1  high whenever state is not IDLE.
REQ-015 OVERCURRENT  output  1  sticky flag, sample exceeded ADC_CMP.
REQ-016 FRAME_ERR  output  1  sticky flag, a lead bit was sampled as 1.

Function
REQ-017 SHALL register LATCH and detect a rising edge as current sample 1, previous sample 0; a level held high SHALL NOT retrigger.
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, DONE, QUIET; all outputs registered.
REQ-019 IDLE -> SETUP on the edge where a rising LATCH edge is detected or a pending request exists; CS_N low from that edge.
REQ-020 SETUP SHALL last CLK_DIV cycles with SCLK high, then enter SHIFT.
REQ-021 SHIFT SHALL produce LEAD_BITS+DATA_BITS SCLK periods: SCLK low CLK_DIV cycles, then high CLK_DIV cycles.
REQ-022 SDO SHALL be sampled on the CLK edge at which SCLK is driven low-to-high, shifting into a 16-bit register MSB first.
REQ-023 Any lead-bit sample equal to 1 SHALL set FRAME_ERR; cleared only by reset.
REQ-024 After the last SCLK high phase the FSM SHALL enter DONE for exactly 1 cycle: CS_N high, ADC loaded with the DATA_BITS data bits, VALID high.
REQ-025 In DONE, if loaded value > ADC_CMP (unsigned, strict), OVERCURRENT SHALL be set; equality SHALL NOT set it.
REQ-026 CLR_OC high SHALL clear OVERCURRENT next edge; set in DONE wins over simultaneous CLR_OC.
REQ-027 QUIET SHALL hold CS_N high, SCLK high for CLK_DIV cycles, then return to IDLE.
REQ-028 A rising LATCH edge while BUSY SHALL set one pending flag; further edges while pending SHALL be dropped; the flag clears on entry to SETUP.
REQ-029 CS_N low duration SHALL be CLK_DIV*(1+2*(LEAD_BITS+DATA_BITS)) cycles; 132 at defaults.
REQ-030 ADC SHALL hold its value between DONE cycles; ADC_CMP SHALL be sampled only in DONE.

Reset
REQ-031 RESET_N low SHALL immediately force: state IDLE, CS_N 1, SCLK 1, ADC 0, VALID 0, BUSY 0, OVERCURRENT 0, FRAME_ERR 0, pending 0, LATCH history 0.
REQ-032 Reset mid-conversion SHALL abort the frame with no VALID pulse and no ADC update.
REQ-033 After RESET_N release, LATCH already high SHALL count as a rising edge on the first sampled edge.

Verification
REQ-034 Defaults, SDO model returns 0x0ABC after 4 zeros, LATCH pulse -> CS_N low 132 cycles, 16 SCLK falls, ADC=0x0ABC, VALID 1 cycle, FRAME_ERR 0.
REQ-035 ADC_CMP=0x800, samples 0x800 then 0x801 -> OVERCURRENT stays 0 after first, 1 after second; CLR_OC same cycle as DONE -> stays 1; CLR_OC later -> 0.
REQ-036 Two LATCH edges during one conversion -> exactly two conversions total, second CS_N fall exactly CLK_DIV cycles after first CS_N rise plus 1 IDLE cycle.
REQ-037 RESET_N low at SCLK period 7 -> CS_N, SCLK 1 asynchronously, ADC 0, no VALID; next LATCH gives a clean full frame.
REQ-038 SDO model sends lead bits 0100 -> FRAME_ERR 1, ADC still updated, flag persists across following clean frames.
REQ-039 CLK_DIV=2, LATCH held high 500 cycles -> exactly one conversion, CS_N low 66 cycles.

Source files
------------

// File: rtl/adc_reader.sv
// adc_reader: frames a serial ADC read on LATCH, checks the lead bits
// and compares each conversion against an overcurrent threshold.
//
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   LATCH             conversion request, rising edge triggers
//   ADC_CMP           unsigned overcurrent threshold
//   CLR_OC            synchronous clear of OVERCURRENT
//   SDO               serial data from the ADC
//   CS_N, SCLK        ADC chip select and serial clock
//   ADC, VALID        last conversion and its one-cycle update strobe
//   BUSY              high while a frame is in progress
//   OVERCURRENT       sticky, a conversion exceeded ADC_CMP
//   FRAME_ERR         sticky, a lead bit was sampled as 1

module adc_reader #(
    parameter int CLK_DIV   = 4,
    parameter int LEAD_BITS = 4,
    parameter int DATA_BITS = 12
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 LATCH,
    input  logic [DATA_BITS-1:0] ADC_CMP,
    input  logic                 CLR_OC,
    input  logic                 SDO,
    output logic                 CS_N,
    output logic                 SCLK,
    output logic [DATA_BITS-1:0] ADC,
    output logic                 VALID,
    output logic                 BUSY,
    output logic                 OVERCURRENT,
    output logic                 FRAME_ERR
);

    localparam int NBITS = LEAD_BITS + DATA_BITS;
    localparam int BW    = $clog2(NBITS + 1);
    localparam int CW    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_QUIET
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [NBITS-1:0]     shreg_q, shreg_d;
    logic [DATA_BITS-1:0] adc_q, adc_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 oc_q, oc_d;
    logic                 ferr_q, ferr_d;
    logic                 pend_q, pend_d;
    logic                 latch_q, latch_prev_q;
    logic                 rise;
    logic                 last_cnt;

    assign rise     = latch_q & ~latch_prev_q;
    assign last_cnt = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        adc_d   = adc_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        valid_d = 1'b0;
        oc_d    = oc_q;
        ferr_d  = ferr_q;
        pend_d  = pend_q;

        if (CLR_OC) begin
            oc_d = 1'b0;
        end
        // Only one request can be queued behind the running frame.
        if (rise && state_q != S_IDLE) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rise || pend_q) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (last_cnt) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!last_cnt) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // SCLK rises on this edge: capture SDO now.
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[NBITS-2:0], SDO};
                        if (bit_q < BW'(LEAD_BITS) && SDO) begin
                            ferr_d = 1'b1;
                        end
                    end else if (bit_q == BW'(NBITS - 1)) begin
                        state_d = S_DONE;
                        cs_n_d  = 1'b1;
                        adc_d   = shreg_q[DATA_BITS-1:0];
                        valid_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                // A new overcurrent wins over a simultaneous clear.
                if (adc_q > ADC_CMP) begin
                    oc_d = 1'b1;
                end
                state_d = S_QUIET;
                cnt_d   = '0;
            end
            S_QUIET: begin
                if (last_cnt) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            adc_q        <= '0;
            sclk_q       <= 1'b1;
            cs_n_q       <= 1'b1;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            oc_q         <= 1'b0;
            ferr_q       <= 1'b0;
            pend_q       <= 1'b0;
            latch_q      <= 1'b0;
            latch_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            adc_q        <= adc_d;
            sclk_q       <= sclk_d;
            cs_n_q       <= cs_n_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            oc_q         <= oc_d;
            ferr_q       <= ferr_d;
            pend_q       <= pend_d;
            latch_q      <= LATCH;
            latch_prev_q <= latch_q;
        end
    end

    assign CS_N        = cs_n_q;
    assign SCLK        = sclk_q;
    assign ADC         = adc_q;
    assign VALID       = valid_q;
    assign BUSY        = busy_q;
    assign OVERCURRENT = oc_q;
    assign FRAME_ERR   = ferr_q;

endmodule

// File: tb/tb_adc_reader.sv
// tb_adc_reader: randomized scoreboard bench for adc_reader with an
// SPI-style ADC model and a second CLK_DIV=2 instance.

module tb_adc_reader;

    localparam int CD     = 4;
    localparam int NB     = 16;
    localparam int CS_LOW = CD * (1 + 2 * NB);
    localparam int GAP    = 1 + CD + 1;

    typedef struct {
        logic [11:0] adc;
        logic        ferr;
        logic        oc;
    } exp_t;

    logic        CLK = 0;
    logic        RESET_N;
    logic        LATCH = 0;
    logic [11:0] ADC_CMP = 12'hfff;
    logic        CLR_OC = 0;
    logic        SDO = 0;
    logic        CS_N, SCLK, VALID, BUSY, OVERCURRENT, FRAME_ERR;
    logic [11:0] ADC;

    logic        LATCH2 = 0;
    logic        CS_N2, SCLK2, VALID2, BUSY2, OC2, FERR2;
    logic [11:0] ADC2;
    logic [11:0] CMP2 = 12'h000;
    logic        CLR2 = 0;
    logic        SDO2 = 0;

    exp_t        exp_q[$];
    logic [15:0] sdo_q[$];
    logic [15:0] cur_frame = 0;
    int          nfall = 0;
    int          checks = 0;
    int          failures = 0;
    bit          ferr_m = 0;
    bit          oc_m = 0;
    int          cs_frames = 0;
    int          last_gap = 0;

    always #5 CLK = ~CLK;

    adc_reader u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .LATCH(LATCH),
        .ADC_CMP(ADC_CMP), .CLR_OC(CLR_OC), .SDO(SDO),
        .CS_N(CS_N), .SCLK(SCLK), .ADC(ADC), .VALID(VALID),
        .BUSY(BUSY), .OVERCURRENT(OVERCURRENT), .FRAME_ERR(FRAME_ERR)
    );

    adc_reader #(.CLK_DIV(2)) u_dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .LATCH(LATCH2),
        .ADC_CMP(CMP2), .CLR_OC(CLR2), .SDO(SDO2),
        .CS_N(CS_N2), .SCLK(SCLK2), .ADC(ADC2), .VALID(VALID2),
        .BUSY(BUSY2), .OVERCURRENT(OC2), .FRAME_ERR(FERR2)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ADC model: next bit presented after every SCLK fall, MSB first.
    always @(negedge CS_N) begin
        if (sdo_q.size() > 0) cur_frame = sdo_q.pop_front();
        else cur_frame = 16'h0;
        nfall = 0;
    end

    always @(negedge SCLK) begin
        if (nfall < 16) SDO = cur_frame[15 - nfall];
        else SDO = 1'b0;
        nfall++;
    end

    // Scoreboard monitor.
    always begin
        exp_t e;
        @(negedge CLK);
        if (RESET_N && VALID) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("adc", 32'(ADC), 32'(e.adc));
                check("frame_err", 32'(FRAME_ERR), 32'(e.ferr));
                @(negedge CLK);
                check("valid_width", 32'(VALID), 0);
                check("overcurrent", 32'(OVERCURRENT), 32'(e.oc));
            end
        end
    end

    // Frame shape monitor: CS_N low time, SCLK falls, CS_N high gap.
    always begin
        int  low_c, falls, high_c;
        bit  in_f, sp;
        low_c = 0; falls = 0; high_c = 0; in_f = 0; sp = 1;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                low_c = 0; falls = 0; high_c = 0; in_f = 0;
            end else if (!CS_N) begin
                if (!in_f) begin
                    last_gap = high_c;
                    cs_frames++;
                end
                in_f = 1;
                low_c++;
                if (sp && !SCLK) falls++;
            end else if (in_f) begin
                check("cs_low_cycles", low_c, CS_LOW);
                check("sclk_falls", falls, NB);
                in_f = 0; low_c = 0; falls = 0; high_c = 1;
            end else begin
                high_c++;
            end
            sp = SCLK;
        end
    end

    task automatic issue(logic [15:0] frame, logic [11:0] cmp,
                         bit clr_done);
        exp_t e;
        ADC_CMP = cmp;
        if (frame[15:12] != 0) ferr_m = 1;
        if (frame[11:0] > cmp) oc_m = 1;
        else if (clr_done) oc_m = 0;
        e.adc = frame[11:0];
        e.ferr = ferr_m;
        e.oc = oc_m;
        exp_q.push_back(e);
        sdo_q.push_back(frame);
    endtask

    task automatic pulse_latch();
        @(negedge CLK);
        LATCH = 1;
        repeat (2) @(negedge CLK);
        LATCH = 0;
    endtask

    task automatic wait_idle();
        int n;
        repeat (3) @(negedge CLK);
        n = 0;
        while (BUSY && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) check("busy_timeout", 1, 0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic run_frame(logic [15:0] frame, logic [11:0] cmp,
                             bit clr_done);
        int n;
        issue(frame, cmp, clr_done);
        pulse_latch();
        if (clr_done) begin
            n = 0;
            while (n < 400) begin
                @(negedge CLK);
                n++;
                if (VALID) break;
            end
            if (!VALID) check("valid_timeout", 1, 0);
            CLR_OC = 1;
            @(negedge CLK);
            CLR_OC = 0;
        end
        wait_idle();
    endtask

    task automatic clear_oc();
        @(negedge CLK);
        CLR_OC = 1;
        @(negedge CLK);
        CLR_OC = 0;
        oc_m = 0;
        check("oc_cleared", 32'(OVERCURRENT), 0);
    endtask

    initial begin
        int f0, n, falls, lo2, fl2, v2;
        bit sp, cp;
        logic [15:0] fr;

        RESET_N = 0;
        repeat (3) @(negedge CLK);
        check("rst_cs_n", 32'(CS_N), 1);
        check("rst_sclk", 32'(SCLK), 1);
        check("rst_adc", 32'(ADC), 0);
        check("rst_valid", 32'(VALID), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_oc", 32'(OVERCURRENT), 0);
        check("rst_ferr", 32'(FRAME_ERR), 0);
        RESET_N = 1;
        repeat (3) @(negedge CLK);

        run_frame(16'h0abc, 12'hfff, 0);

        run_frame(16'h0800, 12'h800, 0);
        check("oc_equal_no_set", 32'(OVERCURRENT), 0);
        run_frame(16'h0801, 12'h800, 1);
        check("oc_set_beats_clr", 32'(OVERCURRENT), 1);
        clear_oc();

        for (int i = 0; i < 6; i++) begin
            fr = {4'h0, 12'($urandom)};
            run_frame(fr, 12'($urandom), 0);
            if (oc_m) clear_oc();
        end

        f0 = cs_frames;
        issue({4'h0, 12'($urandom)}, 12'hfff, 0);
        issue({4'h0, 12'($urandom)}, 12'hfff, 0);
        pulse_latch();
        repeat (20) @(negedge CLK);
        pulse_latch();
        repeat (10) @(negedge CLK);
        pulse_latch();
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("double_drained", exp_q.size(), 0);
        wait_idle();
        repeat (20) @(negedge CLK);
        check("double_frames", cs_frames - f0, 2);
        check("double_gap", last_gap, GAP);

        run_frame({4'b0100, 12'($urandom)}, 12'hfff, 0);
        check("ferr_set", 32'(FRAME_ERR), 1);
        run_frame({4'h0, 12'($urandom)}, 12'hfff, 0);
        check("ferr_sticky", 32'(FRAME_ERR), 1);

        issue(16'h0555, 12'h000, 0);
        pulse_latch();
        falls = 0;
        sp = SCLK;
        n = 0;
        while (falls < 7 && n < 400) begin
            @(negedge CLK);
            n++;
            if (sp && !SCLK && !CS_N) falls++;
            sp = SCLK;
        end
        check("reach_period7", falls, 7);
        RESET_N = 0;
        #1;
        check("arst_cs_n", 32'(CS_N), 1);
        check("arst_sclk", 32'(SCLK), 1);
        check("arst_adc", 32'(ADC), 0);
        check("arst_valid", 32'(VALID), 0);
        check("arst_busy", 32'(BUSY), 0);
        check("arst_ferr", 32'(FRAME_ERR), 0);
        void'(exp_q.pop_back());
        ferr_m = 0;
        oc_m = 0;
        repeat (3) @(negedge CLK);
        RESET_N = 1;
        repeat (5) @(negedge CLK);
        check("no_valid_after_abort", 32'(VALID), 0);
        run_frame({4'h0, 12'($urandom)}, 12'hfff, 0);

        lo2 = 0; fl2 = 0; v2 = 0; cp = CS_N2;
        @(negedge CLK);
        LATCH2 = 1;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (!CS_N2) lo2++;
            if (cp && !CS_N2) fl2++;
            if (VALID2) v2++;
            cp = CS_N2;
        end
        LATCH2 = 0;
        check("div2_frames", fl2, 1);
        check("div2_cs_low", lo2, 2 * (1 + 2 * NB));
        check("div2_valids", v2, 1);
        check("div2_adc", 32'(ADC2), 0);
        check("div2_oc", 32'(OC2), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
